// File: rtl/rv32_pipeline_ctrl_pkg.sv
// Shared types for the rv32 pipeline control slice: scheduler states, the per-stage
// stall/bubble bundle and the NOP word the stage buffers load when bubbled.
package rv32_pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MC_WAIT = 2'd2
    } pipe_ctrl_state_t;

    typedef struct packed {
        logic stall_fetch;
        logic stall_decode;
        logic stall_exec;
        logic bubble_decode;
        logic bubble_exec;
    } pipe_ctrl_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          REG_W     = 5;

endpackage

// File: rtl/rv32_pipeline_ctrl_if.sv
// Status and control bundle between the pipeline stages and the stall/flush scheduler.
interface rv32_pipeline_ctrl_if;
    import rv32_pipeline_ctrl_pkg::*;

    logic             do_jump;
    logic [REG_W-1:0] dec_rs1;
    logic [REG_W-1:0] dec_rs2;
    logic             dec_use_rs1;
    logic             dec_use_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_is_load;
    logic             ex_multicycle;
    logic             mc_done;
    logic             mem_wait;
    logic             stall_fetch;
    logic             stall_decode;
    logic             stall_exec;
    logic             bubble_decode;
    logic             bubble_exec;
    logic             mc_start;
    logic             mc_timeout;

    // master: the scheduler; slave: the pipeline stages it controls
    modport master (
        input  do_jump, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
               ex_rd, ex_is_load, ex_multicycle, mc_done, mem_wait,
        output stall_fetch, stall_decode, stall_exec, bubble_decode,
               bubble_exec, mc_start, mc_timeout
    );

    modport slave (
        output do_jump, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
               ex_rd, ex_is_load, ex_multicycle, mc_done, mem_wait,
        input  stall_fetch, stall_decode, stall_exec, bubble_decode,
               bubble_exec, mc_start, mc_timeout
    );

endinterface

// File: rtl/rv32_hazard_detect.sv
// Combinational load-use compare between the decode sources and the exec destination.
// Kept separate so bypass logic can reuse the same per-source match.
module rv32_hazard_detect
    import rv32_pipeline_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] dec_rs1,
    input  logic [REG_W-1:0] dec_rs2,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    output logic             hazard
);

    logic [REG_W-1:0] src [2];
    logic [1:0]       use_src;
    logic [1:0]       match;

    assign src[0]  = dec_rs1;
    assign src[1]  = dec_rs2;
    assign use_src = {dec_use_rs2, dec_use_rs1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign match[gi] = use_src[gi] && (src[gi] == ex_rd);
        end
    endgenerate

    // x0 is hardwired, so a load targeting it never produces a value to wait for
    assign hazard = ex_is_load && (ex_rd != '0) && (|match);

endmodule

// File: rtl/rv32_pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage rv32 pipeline: jump flushes, load-use stalls,
// multi-cycle op sequencing with watchdog, and memory wait-state freezing.
module rv32_pipeline_ctrl
    import rv32_pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES  = 1,
    parameter int MC_MAX_CYCLES = 34
) (
    input  logic                 clk,
    input  logic                 reset,
    rv32_pipeline_ctrl_if.master pipe
);

    localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam int WCNT_W = $clog2(MC_MAX_CYCLES + 1);
    localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FCNT_ONE    = FCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_LAST   = WCNT_W'(MC_MAX_CYCLES - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE    = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_SAT    = '1;

    pipe_ctrl_state_t  state_reg, state_next;
    logic [FCNT_W-1:0] fcnt_reg, fcnt_next;
    logic [WCNT_W-1:0] wcnt_reg, wcnt_next;
    logic              timeout_reg, timeout_next;
    pipe_ctrl_t        ctrl;
    logic              mc_start_c;
    logic              load_use;

    rv32_hazard_detect u_hazard (
        .dec_rs1     (pipe.dec_rs1),
        .dec_rs2     (pipe.dec_rs2),
        .dec_use_rs1 (pipe.dec_use_rs1),
        .dec_use_rs2 (pipe.dec_use_rs2),
        .ex_rd       (pipe.ex_rd),
        .ex_is_load  (pipe.ex_is_load),
        .hazard      (load_use)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= RUN;
            fcnt_reg    <= '0;
            wcnt_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            fcnt_reg    <= fcnt_next;
            wcnt_reg    <= wcnt_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        fcnt_next    = fcnt_reg;
        wcnt_next    = wcnt_reg;
        timeout_next = timeout_reg;
        ctrl         = '0;
        mc_start_c   = 1'b0;

        if (pipe.mem_wait) begin
            // whole pipe holds; FSM and counters keep their values
            ctrl.stall_fetch  = 1'b1;
            ctrl.stall_decode = 1'b1;
            ctrl.stall_exec   = 1'b1;
        end else begin
            unique case (state_reg)
                RUN: begin
                    if (pipe.do_jump) begin
                        ctrl.bubble_decode = 1'b1;
                        ctrl.bubble_exec   = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_next = FLUSH;
                            fcnt_next  = FCNT_RELOAD;
                        end
                    end else if (pipe.ex_multicycle) begin
                        mc_start_c        = 1'b1;
                        ctrl.stall_fetch  = 1'b1;
                        ctrl.stall_decode = 1'b1;
                        ctrl.stall_exec   = 1'b1;
                        state_next        = MC_WAIT;
                        wcnt_next         = '0;
                    end else if (load_use) begin
                        ctrl.stall_fetch  = 1'b1;
                        ctrl.stall_decode = 1'b1;
                        ctrl.bubble_exec  = 1'b1;
                    end
                end
                FLUSH: begin
                    // exec holds a bubble here, so a do_jump cannot be genuine
                    ctrl.bubble_decode = 1'b1;
                    fcnt_next          = fcnt_reg - FCNT_ONE;
                    if (fcnt_reg == FCNT_ONE) begin
                        state_next = RUN;
                    end
                end
                MC_WAIT: begin
                    if (pipe.mc_done) begin
                        state_next = RUN;
                    end else if (wcnt_reg == WCNT_LAST) begin
                        // abandon the op: release exec so the same instr is never restarted
                        timeout_next = 1'b1;
                        state_next   = RUN;
                    end else begin
                        ctrl.stall_fetch  = 1'b1;
                        ctrl.stall_decode = 1'b1;
                        ctrl.stall_exec   = 1'b1;
                        if (wcnt_reg != WCNT_SAT) begin
                            wcnt_next = wcnt_reg + WCNT_ONE;
                        end
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // combinational outputs are forced low while reset is held
    assign pipe.stall_fetch   = ctrl.stall_fetch   & ~reset;
    assign pipe.stall_decode  = ctrl.stall_decode  & ~reset;
    assign pipe.stall_exec    = ctrl.stall_exec    & ~reset;
    assign pipe.bubble_decode = ctrl.bubble_decode & ~reset;
    assign pipe.bubble_exec   = ctrl.bubble_exec   & ~reset;
    assign pipe.mc_start      = mc_start_c         & ~reset;
    assign pipe.mc_timeout    = timeout_reg;

endmodule

// File: tb/tb_rv32_pipeline_ctrl.sv
// Directed bench for rv32_pipeline_ctrl built with FLUSH_CYCLES=3, MC_MAX_CYCLES=8.
// Output vector order: {stall_fetch, stall_decode, stall_exec, bubble_decode, bubble_exec, mc_start, mc_timeout}.
module tb_rv32_pipeline_ctrl;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    rv32_pipeline_ctrl_if pipe_bus ();

    rv32_pipeline_ctrl #(
        .FLUSH_CYCLES  (3),
        .MC_MAX_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pipe  (pipe_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] outs();
        return {pipe_bus.stall_fetch, pipe_bus.stall_decode, pipe_bus.stall_exec,
                pipe_bus.bubble_decode, pipe_bus.bubble_exec, pipe_bus.mc_start,
                pipe_bus.mc_timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pipe_bus.do_jump       = 1'b0;
        pipe_bus.dec_rs1       = 5'd0;
        pipe_bus.dec_rs2       = 5'd0;
        pipe_bus.dec_use_rs1   = 1'b0;
        pipe_bus.dec_use_rs2   = 1'b0;
        pipe_bus.ex_rd         = 5'd0;
        pipe_bus.ex_is_load    = 1'b0;
        pipe_bus.ex_multicycle = 1'b0;
        pipe_bus.mc_done       = 1'b0;
        pipe_bus.mem_wait      = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        reset = 1'b1;
        clear_inputs();
        pipe_bus.do_jump       = 1'b1;
        pipe_bus.ex_multicycle = 1'b1;
        pipe_bus.mem_wait      = 1'b1;
        #3;
        got = outs();
        compared++;
        if (got !== 7'b0000000) begin
            mismatched++;
            $display("FAIL reset_hold got=%b want=%b", got, 7'b0000000);
        end else $display("reset_hold outs=%b", got);
        tick();
        clear_inputs();
        reset = 1'b0;
        #2;
        got = outs();
        compared++;
        if (got !== 7'b0000000) begin
            mismatched++;
            $display("FAIL reset_release got=%b want=%b", got, 7'b0000000);
        end else $display("reset_release outs=%b", got);
        tick();
    endtask

    task automatic test_load_use();
        // c0: rs2 hit, c1: load gone, c2: rs1 hit, c3: match but source unused
        logic [6:0] exp_v [4] = '{7'b1100100, 7'b0000000, 7'b1100100, 7'b0000000};
        logic [6:0] got;
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            case (c)
                0: begin
                    pipe_bus.ex_is_load = 1'b1; pipe_bus.ex_rd = 5'd5;
                    pipe_bus.dec_use_rs2 = 1'b1; pipe_bus.dec_rs2 = 5'd5;
                end
                1: begin
                    pipe_bus.dec_use_rs2 = 1'b1; pipe_bus.dec_rs2 = 5'd5;
                end
                2: begin
                    pipe_bus.ex_is_load = 1'b1; pipe_bus.ex_rd = 5'd17;
                    pipe_bus.dec_use_rs1 = 1'b1; pipe_bus.dec_rs1 = 5'd17;
                end
                default: begin
                    pipe_bus.ex_is_load = 1'b1; pipe_bus.ex_rd = 5'd9;
                    pipe_bus.dec_use_rs1 = 1'b0; pipe_bus.dec_rs1 = 5'd9;
                    pipe_bus.dec_use_rs2 = 1'b1; pipe_bus.dec_rs2 = 5'd8;
                end
            endcase
            #2;
            got = outs();
            compared++;
            if (got !== exp_v[c]) begin
                mismatched++;
                $display("FAIL load_use c%0d got=%b want=%b", c, got, exp_v[c]);
            end else $display("load_use c%0d outs=%b", c, got);
            tick();
        end
    endtask

    task automatic test_rd_zero();
        logic [6:0] got;
        clear_inputs();
        pipe_bus.ex_is_load  = 1'b1;
        pipe_bus.ex_rd       = 5'd0;
        pipe_bus.dec_use_rs1 = 1'b1;
        pipe_bus.dec_rs1     = 5'd0;
        pipe_bus.dec_use_rs2 = 1'b1;
        pipe_bus.dec_rs2     = 5'd0;
        #2;
        got = outs();
        compared++;
        if (got !== 7'b0000000) begin
            mismatched++;
            $display("FAIL rd_zero got=%b want=%b", got, 7'b0000000);
        end else $display("rd_zero outs=%b", got);
        tick();
    endtask

    task automatic test_jump();
        // do_jump also held during the first FLUSH cycle to show it is ignored there
        logic [6:0] exp_v [4] = '{7'b0001100, 7'b0001000, 7'b0001000, 7'b0000000};
        logic [6:0] got;
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            pipe_bus.do_jump = (c < 2);
            #2;
            got = outs();
            compared++;
            if (got !== exp_v[c]) begin
                mismatched++;
                $display("FAIL jump c%0d got=%b want=%b", c, got, exp_v[c]);
            end else $display("jump c%0d outs=%b", c, got);
            tick();
        end
    endtask

    task automatic test_priority();
        // c0: mem_wait beats all; c1: jump beats multicycle and load-use; c2,c3: flush; c4: idle
        logic [6:0] exp_v [5] = '{7'b1110000, 7'b0001100, 7'b0001000, 7'b0001000, 7'b0000000};
        logic [6:0] got;
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            if (c < 2) begin
                pipe_bus.do_jump       = 1'b1;
                pipe_bus.ex_multicycle = 1'b1;
                pipe_bus.ex_is_load    = 1'b1;
                pipe_bus.ex_rd         = 5'd3;
                pipe_bus.dec_use_rs1   = 1'b1;
                pipe_bus.dec_rs1       = 5'd3;
                pipe_bus.mem_wait      = (c == 0);
            end
            #2;
            got = outs();
            compared++;
            if (got !== exp_v[c]) begin
                mismatched++;
                $display("FAIL priority c%0d got=%b want=%b", c, got, exp_v[c]);
            end else $display("priority c%0d outs=%b", c, got);
            tick();
        end
    endtask

    task automatic test_multicycle(input int done_cycle, input string name);
        logic [6:0] got;
        logic [6:0] want;
        for (int c = 0; c <= done_cycle + 1; c++) begin
            clear_inputs();
            pipe_bus.ex_multicycle = (c <= done_cycle);
            pipe_bus.mc_done       = (c == done_cycle);
            if (c == 0)               want = 7'b1110010;
            else if (c < done_cycle)  want = 7'b1110000;
            else                      want = 7'b0000000;
            #2;
            got = outs();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL %s c%0d got=%b want=%b", name, c, got, want);
            end else $display("%s c%0d outs=%b", name, c, got);
            tick();
        end
    endtask

    task automatic test_timeout();
        // mem_wait on c3,c4 freezes wcnt, so expiry lands on c10 and the flag shows from c11
        logic [6:0] got;
        logic [6:0] want;
        for (int c = 0; c <= 12; c++) begin
            clear_inputs();
            pipe_bus.ex_multicycle = (c <= 10);
            pipe_bus.mem_wait      = (c == 3) || (c == 4);
            if (c == 0)       want = 7'b1110010;
            else if (c < 10)  want = 7'b1110000;
            else if (c == 10) want = 7'b0000000;
            else              want = 7'b0000001;
            #2;
            got = outs();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL timeout c%0d got=%b want=%b", c, got, want);
            end else $display("timeout c%0d outs=%b", c, got);
            tick();
        end
    endtask

    task automatic test_reset_mid_op();
        logic [6:0] got;
        logic [6:0] want;
        // start op and wait until wcnt has reached 5
        for (int c = 0; c <= 6; c++) begin
            clear_inputs();
            pipe_bus.ex_multicycle = 1'b1;
            if (c < 6) tick();
        end
        #2;
        reset = 1'b1;
        #1;
        got = outs();
        compared++;
        if (got !== 7'b0000000) begin
            mismatched++;
            $display("FAIL reset_async got=%b want=%b", got, 7'b0000000);
        end else $display("reset_async outs=%b", got);
        tick();
        clear_inputs();
        reset = 1'b0;
        // c0..c2 idle: nothing may fire; c3 multicycle proves RUN; c4 done
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            pipe_bus.ex_multicycle = (c >= 3);
            pipe_bus.mc_done       = (c == 4);
            if (c == 3) want = 7'b1110010;
            else        want = 7'b0000000;
            #2;
            got = outs();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL reset_after c%0d got=%b want=%b", c, got, want);
            end else $display("reset_after c%0d outs=%b", c, got);
            tick();
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_rd_zero();
        test_jump();
        test_priority();
        test_multicycle(6, "mc_done5");
        test_multicycle(8, "mc_done_at_expiry");
        test_timeout();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
